// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: bus widths, access sizes and controller states.
package load_store_unit_pkg;

  typedef logic [31:0] t_address;
  typedef logic [31:0] t_data;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } t_mem_size;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS0,
    ST_ACCESS1,
    ST_DONE
  } t_lsu_state;

  // Encoding 2'b11 has no enum member and is folded onto a word access.
  function automatic t_mem_size decode_size(input logic [1:0] i_size);
    case (i_size)
      2'b00:   decode_size = MEM_BYTE;
      2'b01:   decode_size = MEM_HALF;
      default: decode_size = MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and memory data port signals of the load/store unit.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_write;
  logic [1:0] i_req_size;
  logic       i_req_unsigned;
  t_address   i_req_address;
  t_data      i_req_wdata;
  logic       o_resp_valid;
  t_data      o_resp_rdata;
  t_address   o_mem_address;
  t_data      o_mem_wdata;
  logic [3:0] o_mem_write_mask;
  logic       o_mem_write_enable;
  t_data      i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_write, i_req_size, i_req_unsigned,
    input  i_req_address, i_req_wdata, i_mem_rdata,
    output o_req_ready, o_resp_valid, o_resp_rdata,
    output o_mem_address, o_mem_wdata, o_mem_write_mask, o_mem_write_enable
  );

  modport master (
    output i_req_valid, i_req_write, i_req_size, i_req_unsigned,
    output i_req_address, i_req_wdata, i_mem_rdata,
    input  o_req_ready, o_resp_valid, o_resp_rdata,
    input  o_mem_address, o_mem_wdata, o_mem_write_mask, o_mem_write_enable
  );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane arithmetic: store lane placement across two words and load
// extraction/extension from the two-word read buffer.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  i_off,
  input  t_mem_size   i_size,
  input  t_data       i_wdata,
  input  logic [63:0] i_buf64,
  input  logic        i_unsigned,
  output logic [7:0]  o_lanes,
  output logic        o_split,
  output logic [63:0] o_wdata64,
  output t_data       o_rdata
);

  logic [2:0]  w_nbytes;
  logic [7:0]  w_base_lanes;
  logic [31:0] w_shifted;
  logic        w_sign;

  always_comb begin
    w_nbytes     = 3'd4;
    w_base_lanes = 8'h0F;
    case (i_size)
      MEM_BYTE: begin w_nbytes = 3'd1; w_base_lanes = 8'h01; end
      MEM_HALF: begin w_nbytes = 3'd2; w_base_lanes = 8'h03; end
      default:  begin w_nbytes = 3'd4; w_base_lanes = 8'h0F; end
    endcase
  end

  assign o_lanes   = w_base_lanes << i_off;
  assign o_split   = ({1'b0, i_off} + w_nbytes) > 3'd4;
  assign o_wdata64 = {32'b0, i_wdata} << {i_off, 3'b000};

  // Only 32 bits past the byte offset can ever belong to the access.
  assign w_shifted = i_buf64[{i_off, 3'b000} +: 32];

  always_comb begin
    w_sign  = 1'b0;
    o_rdata = '0;
    case (i_size)
      MEM_BYTE: begin
        w_sign  = ~i_unsigned & w_shifted[7];
        o_rdata = {{24{w_sign}}, w_shifted[7:0]};
      end
      MEM_HALF: begin
        w_sign  = ~i_unsigned & w_shifted[15];
        o_rdata = {{16{w_sign}}, w_shifted[15:0]};
      end
      default: o_rdata = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequences one load or store at a time onto the memory data port, splitting
// word-straddling accesses into two consecutive word accesses.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  load_store_unit_if.slave   bus
);

  t_lsu_state  r_state;
  t_lsu_state  w_next_state;
  logic        r_write;
  t_mem_size   r_size;
  logic        r_unsigned;
  t_address    r_addr;
  t_data       r_wdata;
  logic [63:0] r_buf64;

  logic        w_accept;
  logic [7:0]  w_lanes;
  logic        w_split;
  logic [63:0] w_wdata64;
  t_data       w_load_data;
  t_address    w_word_addr;

  assign w_accept    = bus.i_req_valid && (r_state == ST_IDLE);
  assign w_word_addr = {r_addr[31:2], 2'b00};

  load_store_unit_align u_align (
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_wdata    (r_wdata),
    .i_buf64    (r_buf64),
    .i_unsigned (r_unsigned),
    .o_lanes    (w_lanes),
    .o_split    (w_split),
    .o_wdata64  (w_wdata64),
    .o_rdata    (w_load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next_state = ST_ACCESS0;
      ST_ACCESS0: w_next_state = w_split ? ST_ACCESS1 : ST_DONE;
      ST_ACCESS1: w_next_state = ST_DONE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write    <= 1'b0;
      r_size     <= MEM_BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_buf64    <= '0;
    end else begin
      if (w_accept) begin
        r_write    <= bus.i_req_write;
        r_size     <= decode_size(bus.i_req_size);
        r_unsigned <= bus.i_req_unsigned;
        r_addr     <= bus.i_req_address;
        r_wdata    <= bus.i_req_wdata;
        r_buf64    <= '0;
      end
      // Read data is sampled at the edge that ends each access cycle.
      if (r_state == ST_ACCESS0 && !r_write) r_buf64[31:0]  <= bus.i_mem_rdata;
      if (r_state == ST_ACCESS1 && !r_write) r_buf64[63:32] <= bus.i_mem_rdata;
    end
  end

  always_comb begin
    bus.o_req_ready        = 1'b0;
    bus.o_resp_valid       = 1'b0;
    bus.o_resp_rdata       = '0;
    bus.o_mem_address      = '0;
    bus.o_mem_wdata        = '0;
    bus.o_mem_write_mask   = '0;
    bus.o_mem_write_enable = 1'b0;
    case (r_state)
      ST_IDLE: bus.o_req_ready = 1'b1;
      ST_ACCESS0: begin
        bus.o_mem_address = w_word_addr;
        if (r_write) begin
          bus.o_mem_wdata        = w_wdata64[31:0];
          bus.o_mem_write_mask   = w_lanes[3:0];
          bus.o_mem_write_enable = 1'b1;
        end
      end
      ST_ACCESS1: begin
        bus.o_mem_address = w_word_addr + 32'd4;
        if (r_write) begin
          bus.o_mem_wdata        = w_wdata64[63:32];
          bus.o_mem_write_mask   = w_lanes[7:4];
          bus.o_mem_write_enable = 1'b1;
        end
      end
      ST_DONE: begin
        bus.o_resp_valid = 1'b1;
        if (!r_write) bus.o_resp_rdata = w_load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-lane memory model on the data port.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] mem [0:255];

  load_store_unit_if bus ();

  load_store_unit dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.i_mem_rdata = mem[bus.o_mem_address[9:2]];

  always @(posedge clk) begin
    if (bus.o_mem_write_enable)
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_write_mask[b])
          mem[bus.o_mem_address[9:2]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge, then scrambles the fields to show they are not reused.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    bus.i_req_valid    = 1'b1;
    bus.i_req_write    = w;
    bus.i_req_size     = sz;
    bus.i_req_unsigned = u;
    bus.i_req_address  = a;
    bus.i_req_wdata    = d;
    @(posedge clk);
    #1;
    bus.i_req_valid    = 1'b0;
    bus.i_req_write    = ~w;
    bus.i_req_size     = 2'b00;
    bus.i_req_address  = 32'hFFFF_FFFF;
    bus.i_req_wdata    = 32'h5A5A_5A5A;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!bus.o_resp_valid && n < 8) begin
      step();
      n++;
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    int n;
    issue(1'b1, 2'b10, 1'b0, a, d);
    wait_resp(n);
    step();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.o_req_ready); end
    n_checks++; if (bus.o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", bus.o_resp_valid); end
    n_checks++; if (bus.o_resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", bus.o_resp_rdata); end
    n_checks++; if (bus.o_mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", bus.o_mem_address); end
    n_checks++; if (bus.o_mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", bus.o_mem_wdata); end
    n_checks++; if (bus.o_mem_write_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask got %h exp 0", bus.o_mem_write_mask); end
    n_checks++; if (bus.o_mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", bus.o_mem_write_enable); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_aligned_word;
    int n;
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678);
    n_checks++; if (bus.o_mem_address !== 32'h100) begin n_fail++; $display("FAIL sw_addr got %h exp 00000100", bus.o_mem_address); end
    n_checks++; if (bus.o_mem_write_mask !== 4'hF) begin n_fail++; $display("FAIL sw_mask got %b exp 1111", bus.o_mem_write_mask); end
    n_checks++; if (bus.o_mem_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL sw_wdata got %h exp 12345678", bus.o_mem_wdata); end
    n_checks++; if (bus.o_mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL sw_we got %b exp 1", bus.o_mem_write_enable); end
    wait_resp(n);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL sw_latency got %0d exp 1", n); end
    n_checks++; if (bus.o_resp_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rdata got %h exp 0", bus.o_resp_rdata); end
    n_checks++; if (bus.o_mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL done_we got %b exp 0", bus.o_mem_write_enable); end
    step();
    n_checks++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready got %b exp 1", bus.o_req_ready); end
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    n_checks++; if (bus.o_mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL lw_we got %b exp 0", bus.o_mem_write_enable); end
    wait_resp(n);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL lw_latency got %0d exp 1", n); end
    n_checks++; if (bus.o_resp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL lw_rdata got %h exp 12345678", bus.o_resp_rdata); end
    step();
    issue(1'b1, 2'b11, 1'b0, 32'h10C, 32'hCAFE_F00D);
    n_checks++; if (bus.o_mem_write_mask !== 4'hF) begin n_fail++; $display("FAIL size11_mask got %b exp 1111", bus.o_mem_write_mask); end
    wait_resp(n);
    step();
    n_checks++; if (mem[8'h43] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL size11_mem got %h exp cafef00d", mem[8'h43]); end
  endtask

  task automatic test_byte_lanes;
    int n;
    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00AB);
    n_checks++; if (bus.o_mem_write_mask !== 4'b1000) begin n_fail++; $display("FAIL sb_mask got %b exp 1000", bus.o_mem_write_mask); end
    n_checks++; if (bus.o_mem_wdata !== 32'hAB00_0000) begin n_fail++; $display("FAIL sb_wdata got %h exp ab000000", bus.o_mem_wdata); end
    wait_resp(n);
    step();
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    wait_resp(n);
    n_checks++; if (bus.o_resp_rdata !== 32'hFFFF_FFAB) begin n_fail++; $display("FAIL lb_rdata got %h exp ffffffab", bus.o_resp_rdata); end
    step();
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    wait_resp(n);
    n_checks++; if (bus.o_resp_rdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL lbu_rdata got %h exp 000000ab", bus.o_resp_rdata); end
    step();
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    wait_resp(n);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL lh_edge_latency got %0d exp 1", n); end
    n_checks++; if (bus.o_resp_rdata !== 32'hFFFF_AB34) begin n_fail++; $display("FAIL lh_rdata got %h exp ffffab34", bus.o_resp_rdata); end
    step();
    issue(1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
    wait_resp(n);
    n_checks++; if (bus.o_resp_rdata !== 32'h0000_5678) begin n_fail++; $display("FAIL lhu_rdata got %h exp 00005678", bus.o_resp_rdata); end
    step();
  endtask

  task automatic test_split_store;
    int n;
    preload(32'h104, 32'h1111_1111);
    preload(32'h108, 32'h2222_2222);
    issue(1'b1, 2'b10, 1'b0, 32'h106, 32'hDEAD_BEEF);
    n_checks++; if (bus.o_mem_address !== 32'h104) begin n_fail++; $display("FAIL ssw_addr0 got %h exp 00000104", bus.o_mem_address); end
    n_checks++; if (bus.o_mem_write_mask !== 4'b1100) begin n_fail++; $display("FAIL ssw_mask0 got %b exp 1100", bus.o_mem_write_mask); end
    n_checks++; if (bus.o_mem_wdata !== 32'hBEEF_0000) begin n_fail++; $display("FAIL ssw_wdata0 got %h exp beef0000", bus.o_mem_wdata); end
    step();
    n_checks++; if (bus.o_mem_address !== 32'h108) begin n_fail++; $display("FAIL ssw_addr1 got %h exp 00000108", bus.o_mem_address); end
    n_checks++; if (bus.o_mem_write_mask !== 4'b0011) begin n_fail++; $display("FAIL ssw_mask1 got %b exp 0011", bus.o_mem_write_mask); end
    n_checks++; if (bus.o_mem_wdata !== 32'h0000_DEAD) begin n_fail++; $display("FAIL ssw_wdata1 got %h exp 0000dead", bus.o_mem_wdata); end
    n_checks++; if (bus.o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL ssw_early_resp got %b exp 0", bus.o_resp_valid); end
    step();
    n_checks++; if (bus.o_resp_valid !== 1'b1) begin n_fail++; $display("FAIL ssw_resp got %b exp 1", bus.o_resp_valid); end
    step();
    n_checks++; if (mem[8'h41] !== 32'hBEEF_1111) begin n_fail++; $display("FAIL ssw_mem0 got %h exp beef1111", mem[8'h41]); end
    n_checks++; if (mem[8'h42] !== 32'h2222_DEAD) begin n_fail++; $display("FAIL ssw_mem1 got %h exp 2222dead", mem[8'h42]); end
    issue(1'b0, 2'b10, 1'b0, 32'h106, 32'h0);
    wait_resp(n);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL slw_latency got %0d exp 2", n); end
    n_checks++; if (bus.o_resp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL slw_rdata got %h exp deadbeef", bus.o_resp_rdata); end
    step();
  endtask

  task automatic test_split_half;
    int n;
    preload(32'h1FC, 32'h8000_0000);
    preload(32'h200, 32'h0000_00FF);
    issue(1'b0, 2'b01, 1'b0, 32'h1FF, 32'h0);
    n_checks++; if (bus.o_mem_address !== 32'h1FC) begin n_fail++; $display("FAIL slh_addr0 got %h exp 000001fc", bus.o_mem_address); end
    step();
    n_checks++; if (bus.o_mem_address !== 32'h200) begin n_fail++; $display("FAIL slh_addr1 got %h exp 00000200", bus.o_mem_address); end
    step();
    n_checks++; if (bus.o_resp_valid !== 1'b1) begin n_fail++; $display("FAIL slh_resp got %b exp 1", bus.o_resp_valid); end
    n_checks++; if (bus.o_resp_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL slh_rdata got %h exp ffffff80", bus.o_resp_rdata); end
    step();
    issue(1'b0, 2'b01, 1'b1, 32'h1FF, 32'h0);
    wait_resp(n);
    n_checks++; if (bus.o_resp_rdata !== 32'h0000_FF80) begin n_fail++; $display("FAIL slhu_rdata got %h exp 0000ff80", bus.o_resp_rdata); end
    step();
  endtask

  task automatic test_wrap;
    int n;
    issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);
    n_checks++; if (bus.o_mem_address !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h exp fffffffc", bus.o_mem_address); end
    step();
    n_checks++; if (bus.o_mem_address !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1 got %h exp 00000000", bus.o_mem_address); end
    wait_resp(n);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL wrap_latency got %0d exp 1", n); end
    step();
  endtask

  task automatic test_reset_mid_split;
    preload(32'h104, 32'h1111_1111);
    preload(32'h108, 32'h2222_2222);
    issue(1'b1, 2'b10, 1'b0, 32'h106, 32'hDEAD_BEEF);
    step();
    n_checks++; if (bus.o_mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL rst_pre_we got %b exp 1", bus.o_mem_write_enable); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_async_we got %b exp 0", bus.o_mem_write_enable); end
    n_checks++; if (bus.o_mem_address !== 32'h0) begin n_fail++; $display("FAIL rst_async_addr got %h exp 0", bus.o_mem_address); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp got %b exp 0", bus.o_resp_valid); end
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", bus.o_req_ready); end
    n_checks++; if (mem[8'h41] !== 32'hBEEF_1111) begin n_fail++; $display("FAIL rst_mem0 got %h exp beef1111", mem[8'h41]); end
    n_checks++; if (mem[8'h42] !== 32'h2222_2222) begin n_fail++; $display("FAIL rst_mem1 got %h exp 22222222", mem[8'h42]); end
  endtask

  task automatic test_back_to_back;
    int last_acc = -1;
    int n_acc = 0;
    int n_resp = 0;
    logic prev_resp = 1'b0;
    bus.i_req_valid    = 1'b1;
    bus.i_req_write    = 1'b0;
    bus.i_req_size     = 2'b10;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_address  = 32'h100;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.o_req_ready) begin
        if (last_acc >= 0) begin
          n_checks++; if (i - last_acc !== 3) begin n_fail++; $display("FAIL b2b_gap got %0d exp 3", i - last_acc); end
        end
        last_acc = i;
        n_acc++;
      end
      if (bus.o_resp_valid) begin
        n_resp++;
        n_checks++; if (prev_resp !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_width got %b exp 0", prev_resp); end
        n_checks++; if (bus.o_resp_rdata !== 32'hAB34_5678) begin n_fail++; $display("FAIL b2b_rdata got %h exp ab345678", bus.o_resp_rdata); end
      end
      prev_resp = bus.o_resp_valid;
    end
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    n_checks++; if (n_acc !== 4) begin n_fail++; $display("FAIL b2b_accepts got %0d exp 4", n_acc); end
    n_checks++; if (n_resp !== 4) begin n_fail++; $display("FAIL b2b_resps got %0d exp 4", n_resp); end
    repeat (3) step();
    n_checks++; if (bus.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got %b exp 1", bus.o_req_ready); end
  endtask

  initial begin
    bus.i_req_valid    = 1'b0;
    bus.i_req_write    = 1'b0;
    bus.i_req_size     = 2'b00;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_address  = '0;
    bus.i_req_wdata    = '0;
    test_reset();
    test_aligned_word();
    test_byte_lanes();
    test_split_store();
    test_split_half();
    test_wrap();
    test_reset_mid_split();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle controller that sequences all core data accesses onto the data port of the unified instruction/data memory. It accepts one load or store request at a time over a valid/ready handshake and derives the word address, byte write mask and lane-shifted store data. For loads it extracts, sign-extends or zero-extends the result. Accesses that straddle a word boundary are split into two consecutive word accesses, so the core never sees misalignment.

## Interface
- No parameters; address and data widths come from `t_address`/`t_data` (32 bits).
- `i_clk` in 1: clock; all state updates on rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: controller idle, request accepted when valid&ready.
- `i_req_write` in 1: 1 = store, 0 = load.
- `i_req_size` in 2: `t_mem_size`: BYTE=00, HALF=01, WORD=10; 11 is treated as WORD.
- `i_req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `i_req_address` in 32: byte address, any alignment.
- `i_req_wdata` in 32: store data, right-aligned (bits [7:0] are the lowest-addressed byte).
- `o_resp_valid` out 1: one-cycle completion pulse, for both loads and stores.
- `o_resp_rdata` out 32: load result, valid with `o_resp_valid`; 0 for stores.
- `o_mem_address` out 32: word-aligned address to the memory data port (bits [1:0] = 0).
- `o_mem_wdata` out 32: lane-positioned store data.
- `o_mem_write_mask` out 4: bit 0 = byte lane [7:0].
- `o_mem_write_enable` out 1: memory write strobe.
- `i_mem_rdata` in 32: asynchronous read data from the memory data port.

## Operation
- States: IDLE, ACCESS0, ACCESS1, DONE.
- **Latch on accept.** In IDLE, valid&ready latches the request and moves to ACCESS0. Derived fields:
  - `off = addr[1:0]`
  - `nbytes` = 1, 2 or 4 by size
  - `lanes = ((1<<nbytes)-1) << off`, 8 bits wide
  - `split = (off + nbytes > 4)`
- **ACCESS0.**
  - `o_mem_address = {addr[31:2],2'b00}`.
  - Store: drive `wdata64 = wdata << (8*off)`, 64 bits wide. Set `o_mem_wdata = wdata64[31:0]`, `o_mem_write_mask = lanes[3:0]` and assert `o_mem_write_enable`.
  - Load: capture `i_mem_rdata` into the low half of a 64-bit read buffer.
  - Next state is ACCESS1 if split, else DONE.
- **ACCESS1.**
  - Address = word address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - Store: drive `wdata64[63:32]` with mask `lanes[7:4]`.
  - Load: capture the high half of the buffer.
  - Next state is DONE.
- **DONE.**
  - `o_resp_valid=1`.
  - Load: `o_resp_rdata = extend((buf64 >> 8*off)[8*nbytes-1:0])`.
  - Next state is IDLE.
- **Idle outputs.** In IDLE and DONE, all `o_mem_*` outputs are 0 and the write enable is low.
- **Backpressure.** `o_req_ready` is high only in IDLE. Responses have no backpressure.

## Timing
- Reset values: state IDLE; `o_req_ready=1`; `o_resp_valid=0`; `o_resp_rdata=0`; `o_mem_address=0`; `o_mem_wdata=0`; `o_mem_write_mask=0`; `o_mem_write_enable=0`.
- The `o_mem_*` outputs are decoded from registered state only; they never depend combinationally on `i_req_*`.
- Latency, request accepted in cycle N:
  - Aligned: access in N+1, `o_resp_valid` in N+2, next accept in N+3 at the earliest.
  - Split: accesses in N+1 and N+2, response in N+3, next accept in N+4.
- A store half commits at the rising edge ending its ACCESS cycle. Load data is sampled at that same edge.
- Reset asserted in any state:
  - Immediate return to IDLE; write enable drops asynchronously; the in-flight response is discarded.
  - For a split store reset during ACCESS1, the first-half bytes remain written and the second word is untouched.
- `i_req_*` is ignored while `o_req_ready=0`. Request fields may change freely after acceptance.

## Structure
- Package `definitions` gains:
  - `t_mem_size` enum: MEM_BYTE, MEM_HALF, MEM_WORD.
  - `t_lsu_state` enum.
- Sub-module `lsu_align` is purely combinational and holds all lane arithmetic:
  - Computes `lanes`, `split` and `wdata64` from off/size/wdata.
  - Performs load extraction and extension from buf64/off/size/unsigned.
- The top level holds the FSM and request/read-buffer registers.

## Test plan
- **Aligned word.** SW 0x12345678 @0x100: one cycle with address 0x100, mask 1111, wdata 0x12345678; resp_valid at N+2. Then LW 0x100 returns 0x12345678.
- **Byte lane and extension.** SB 0xAB @0x103: mask 1000, wdata 0xAB000000. LB 0x103 returns 0xFFFFFFAB; LBU 0x103 returns 0x000000AB.
- **Split word store/load.** SW 0xDEADBEEF @0x106:
  - Cycle 1: address 0x104, mask 1100, wdata 0xBEEF0000.
  - Cycle 2: address 0x108, mask 0011, wdata 0x0000DEAD.
  - resp_valid at N+3; LW 0x106 returns 0xDEADBEEF.
- **Split half load.** Preload word 0x1FC = 0x80000000 and word 0x200 = 0x000000FF. LH 0x1FF returns 0xFFFFFF80; LHU 0x1FF returns 0x0000FF80.
- **Address wrap.** LW 0xFFFFFFFE accesses 0xFFFFFFFC, then 0x00000000.
- **Reset mid-split and back-to-back.** Reset during ACCESS1 of the split store above: write enable low immediately; ready=1 after release; 0x104 holds the new bytes, 0x108 is unchanged. With valid held high and back-to-back aligned requests, accepts occur every 3 cycles and resp_valid never exceeds one cycle.
